// File: rtl/tile_load_sequencer.sv
// tile_load_sequencer
// Host-side sequencer for one accelerator tile: loads ifmap, kernel and
// optional bias words from a 64-bit stream into the accelerator buffers,
// launches the operation, waits for completion and streams the ofmap back.
// Optional feature macro: TILE_SEQ_BIAS_EN (bias load phase present when defined).
module tile_load_sequencer #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] n_ifmap,
    input  logic [AW-1:0] n_wght,
    input  logic [1:0]    n_bias,
    input  logic [AW-1:0] n_ofmap,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          config_load,
    output logic          config_done,
    output logic          ifmap_en,
    output logic [7:0]    ifmap_wen,
    output logic [AW-1:0] ifmap_addrin,
    output logic [DW-1:0] ifmap_din,
    output logic          wght_en,
    output logic [7:0]    wght_wen,
    output logic [AW-1:0] wght_addrin,
    output logic [DW-1:0] wght_din,
    output logic          bias_write,
    output logic          ifmap_ready,
    output logic          wght_ready,
    input  logic          dataload_ready,
    output logic          op_go,
    input  logic          tile_done,
    output logic          op_done,
    output logic          ofmap_en,
    output logic [AW-1:0] ofmap_addrin,
    input  logic [DW-1:0] ofmap_dout,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE,
        CFG_LD,
        CFG_DN,
        LD_IF,
        LD_WT,
`ifdef TILE_SEQ_BIAS_EN
        LD_BI,
`endif
        WAIT_RDY,
        GO,
        RUN,
        RD_ADDR,
        RD_DATA,
        RD_OUT,
        FIN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wc_q;
    logic [AW-1:0] rc_q;
    logic [AW-1:0] n_ifmap_q;
    logic [AW-1:0] n_wght_q;
    logic [AW-1:0] n_ofmap_q;
    logic [DW-1:0] out_data_q;

`ifdef TILE_SEQ_BIAS_EN
    logic [1:0]    n_bias_q;
`else
    // Bias count has no destination when the bias phase is compiled out.
    logic          unused_n_bias;
    assign unused_n_bias = ^n_bias;
`endif

    state_t        first_phase;
    state_t        after_if;
    state_t        after_wt;
    state_t        next_load;
    logic [AW-1:0] cur_n;
    logic          last_word;
    logic          last_read;
    logic          in_ifmap;
    logic          in_wght;
    logic          in_bias;
    logic          hs;

    assign in_ifmap = (state_q == LD_IF);
`ifdef TILE_SEQ_BIAS_EN
    assign in_bias  = (state_q == LD_BI);
`else
    assign in_bias  = 1'b0;
`endif
    assign in_wght  = (state_q == LD_WT) || in_bias;

    // The stream is only accepted while a load phase is active.
    assign in_ready = in_ifmap || in_wght;
    assign hs       = in_valid && in_ready;

    // Buffer write strobes follow the stream handshake directly; address and
    // data are gated so the ports sit at zero between writes.
    assign ifmap_en     = hs && in_ifmap;
    assign ifmap_wen    = (hs && in_ifmap) ? 8'hFF : 8'h00;
    assign ifmap_addrin = (hs && in_ifmap) ? wc_q : '0;
    assign ifmap_din    = (hs && in_ifmap) ? in_data : '0;

    assign wght_en      = hs && in_wght;
    assign wght_wen     = (hs && in_wght) ? 8'hFF : 8'h00;
    assign wght_addrin  = (hs && in_wght) ? wc_q : '0;
    assign wght_din     = (hs && in_wght) ? in_data : '0;
    assign bias_write   = in_bias;

    // Remaining outputs are pure decodes of the state register.
    assign config_load  = (state_q == CFG_LD);
    assign config_done  = (state_q == CFG_DN);
    assign ifmap_ready  = (state_q == WAIT_RDY);
    assign wght_ready   = (state_q == WAIT_RDY);
    assign op_go        = (state_q == GO);
    assign op_done      = (state_q == FIN);
    assign ofmap_en     = (state_q == RD_ADDR);
    assign ofmap_addrin = (state_q == RD_ADDR) ? rc_q : '0;
    assign out_valid    = (state_q == RD_OUT);
    assign out_data     = out_data_q;
    assign busy         = (state_q != IDLE);

    // Phase chaining: zero-count phases are skipped within the same transition.
    always_comb begin
        after_wt = WAIT_RDY;
`ifdef TILE_SEQ_BIAS_EN
        if (n_bias_q != 2'd0) begin
            after_wt = LD_BI;
        end
`endif
        after_if    = (n_wght_q != '0) ? LD_WT : after_wt;
        first_phase = (n_ifmap_q != '0) ? LD_IF : after_if;
        cur_n       = '0;
        next_load   = WAIT_RDY;
        case (state_q)
            LD_IF: begin
                cur_n     = n_ifmap_q;
                next_load = after_if;
            end
            LD_WT: begin
                cur_n     = n_wght_q;
                next_load = after_wt;
            end
`ifdef TILE_SEQ_BIAS_EN
            LD_BI: begin
                cur_n     = AW'(n_bias_q);
                next_load = WAIT_RDY;
            end
`endif
            default: begin
                cur_n     = '0;
                next_load = WAIT_RDY;
            end
        endcase
    end

    assign last_word = (wc_q == cur_n - AW'(1));
    assign last_read = (rc_q == n_ofmap_q - AW'(1));

    // Tile sequencing FSM with word/readback counters and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wc_q       <= '0;
            rc_q       <= '0;
            n_ifmap_q  <= '0;
            n_wght_q   <= '0;
            n_ofmap_q  <= '0;
            out_data_q <= '0;
`ifdef TILE_SEQ_BIAS_EN
            n_bias_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_ifmap_q <= n_ifmap;
                        n_wght_q  <= n_wght;
                        n_ofmap_q <= n_ofmap;
`ifdef TILE_SEQ_BIAS_EN
                        n_bias_q  <= n_bias;
`endif
                        wc_q      <= '0;
                        rc_q      <= '0;
                        state_q   <= CFG_LD;
                    end
                end
                CFG_LD: state_q <= CFG_DN;
                CFG_DN: begin
                    wc_q    <= '0;
                    state_q <= first_phase;
                end
                LD_IF, LD_WT
`ifdef TILE_SEQ_BIAS_EN
                , LD_BI
`endif
                : begin
                    if (hs) begin
                        if (last_word) begin
                            wc_q    <= '0;
                            state_q <= next_load;
                        end else begin
                            wc_q <= wc_q + AW'(1);
                        end
                    end
                end
                WAIT_RDY: begin
                    if (dataload_ready) begin
                        state_q <= GO;
                    end
                end
                GO: state_q <= RUN;
                RUN: begin
                    if (tile_done) begin
                        state_q <= (n_ofmap_q == '0) ? FIN : RD_ADDR;
                    end
                end
                RD_ADDR: state_q <= RD_DATA;
                RD_DATA: begin
                    out_data_q <= ofmap_dout;
                    state_q    <= RD_OUT;
                end
                RD_OUT: begin
                    if (out_ready) begin
                        if (last_read) begin
                            rc_q    <= '0;
                            state_q <= FIN;
                        end else begin
                            rc_q    <= rc_q + AW'(1);
                            state_q <= RD_ADDR;
                        end
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Directed testbench for tile_load_sequencer.
// Expectations for the bias phase follow TILE_SEQ_BIAS_EN as compiled.
module tb_tile_load_sequencer;

    localparam int AW = 10;
    localparam int DW = 64;
`ifdef TILE_SEQ_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] n_ifmap;
    logic [AW-1:0] n_wght;
    logic [1:0]    n_bias;
    logic [AW-1:0] n_ofmap;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          config_load;
    logic          config_done;
    logic          ifmap_en;
    logic [7:0]    ifmap_wen;
    logic [AW-1:0] ifmap_addrin;
    logic [DW-1:0] ifmap_din;
    logic          wght_en;
    logic [7:0]    wght_wen;
    logic [AW-1:0] wght_addrin;
    logic [DW-1:0] wght_din;
    logic          bias_write;
    logic          ifmap_ready;
    logic          wght_ready;
    logic          dataload_ready;
    logic          op_go;
    logic          tile_done;
    logic          op_done;
    logic          ofmap_en;
    logic [AW-1:0] ofmap_addrin;
    logic [DW-1:0] ofmap_dout;
    logic          busy;

    tile_load_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .n_ifmap(n_ifmap), .n_wght(n_wght), .n_bias(n_bias), .n_ofmap(n_ofmap),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .config_load(config_load), .config_done(config_done),
        .ifmap_en(ifmap_en), .ifmap_wen(ifmap_wen), .ifmap_addrin(ifmap_addrin), .ifmap_din(ifmap_din),
        .wght_en(wght_en), .wght_wen(wght_wen), .wght_addrin(wght_addrin), .wght_din(wght_din),
        .bias_write(bias_write), .ifmap_ready(ifmap_ready), .wght_ready(wght_ready),
        .dataload_ready(dataload_ready), .op_go(op_go), .tile_done(tile_done), .op_done(op_done),
        .ofmap_en(ofmap_en), .ofmap_addrin(ofmap_addrin), .ofmap_dout(ofmap_dout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    wen;
        logic          bw;
    } wr_t;

    wr_t         if_q[$];
    wr_t         wt_q[$];
    logic [63:0] out_q[$];

    int n_asserts = 0;
    int n_fail    = 0;

    // Driver configuration and state
    int          drv_on = 0;
    int          vpat, ack_dly, stall;
    int          idx, rdy_cnt, go_wait, ov_cnt, dcyc;
    logic [15:0] tile_id;

    // Monitor statistics
    int mcyc = 0;
    int start_cyc, cl_cyc, cl_cnt, cd_cyc, cd_cnt, ir_first, ir_cycles;
    int wt_last, rdy_first, rdy_last, rdy_cycles, rw_diff, go_cyc, go_cnt;
    int td_cyc, of_first, of_cnt, done_cnt, bw_cycles, ov_cycles, unstable;
    logic        prev_stall;
    logic [63:0] prev_od;

    function automatic logic [63:0] word(input logic [15:0] t, input int i);
        return {16'hD0D0, t, i[31:0]};
    endfunction

    function automatic logic [63:0] ofm(input logic [AW-1:0] a);
        return 64'hFEED_BEEF_0000_0000 | {54'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ofmap buffer model with one-cycle read latency
    always @(posedge clk) begin
        if (ofmap_en) ofmap_dout <= ofm(ofmap_addrin);
    end

    // Stimulus driver: acts on the falling edge
    initial begin
        in_valid = 0; in_data = '0; dataload_ready = 0; tile_done = 0; out_ready = 0;
        forever begin
            @(negedge clk);
            if (drv_on != 0) begin
                dcyc++;
                in_valid = (vpat == 0) ? 1'b1 : dcyc[0];
                in_data  = word(tile_id, idx);
                if (in_valid && in_ready) idx++;
                if (ifmap_ready) rdy_cnt++;
                dataload_ready = ifmap_ready && (rdy_cnt > ack_dly);
                if (op_go) go_wait = 1;
                else if (go_wait > 0) go_wait++;
                tile_done = (go_wait == 3);
                if (out_valid) ov_cnt++;
                out_ready = out_valid && (ov_cnt > stall);
                if (out_ready) ov_cnt = 0;
            end else begin
                in_valid = 0; dataload_ready = 0; tile_done = 0; out_ready = 0;
            end
        end
    end

    // Monitor: samples 2 time units after the falling edge
    initial begin
        forever begin
            wr_t e;
            @(negedge clk);
            #2;
            mcyc++;
            if (start && start_cyc < 0) start_cyc = mcyc;
            if (config_load) begin cl_cnt++; cl_cyc = mcyc; end
            if (config_done) begin cd_cnt++; cd_cyc = mcyc; end
            if (in_ready) begin ir_cycles++; if (ir_first < 0) ir_first = mcyc; end
            if (ifmap_en) begin
                e.addr = ifmap_addrin; e.data = ifmap_din; e.wen = ifmap_wen; e.bw = 1'b0;
                if_q.push_back(e);
            end
            if (wght_en) begin
                e.addr = wght_addrin; e.data = wght_din; e.wen = wght_wen; e.bw = bias_write;
                wt_q.push_back(e);
                wt_last = mcyc;
            end
            if (bias_write) bw_cycles++;
            if (ifmap_ready) begin
                rdy_cycles++;
                if (rdy_first < 0) rdy_first = mcyc;
                rdy_last = mcyc;
            end
            if (ifmap_ready !== wght_ready) rw_diff++;
            if (op_go) begin go_cnt++; go_cyc = mcyc; end
            if (tile_done) td_cyc = mcyc;
            if (ofmap_en) begin of_cnt++; if (of_first < 0) of_first = mcyc; end
            if (out_valid) begin
                ov_cycles++;
                if (prev_stall && out_data !== prev_od) unstable++;
            end
            prev_stall = out_valid && !out_ready;
            prev_od    = out_data;
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (op_done) done_cnt++;
        end
    end

    task automatic clear_stats();
        if_q.delete(); wt_q.delete(); out_q.delete();
        start_cyc = -1; cl_cyc = -1; cl_cnt = 0; cd_cyc = -1; cd_cnt = 0;
        ir_first = -1; ir_cycles = 0; wt_last = -1; rdy_first = -1; rdy_last = -1;
        rdy_cycles = 0; rw_diff = 0; go_cyc = -1; go_cnt = 0; td_cyc = -1;
        of_first = -1; of_cnt = 0; done_cnt = 0; bw_cycles = 0; ov_cycles = 0;
        unstable = 0; prev_stall = 0; prev_od = '0;
    endtask

    // Configure driver and pulse start; counts are scrambled afterwards
    task automatic launch(input logic [15:0] t, input int ni, input int nw, input int nb,
                          input int no, input int vp, input int ack, input int stl);
        @(posedge clk); #1;
        tile_id = t; vpat = vp; ack_dly = ack; stall = stl;
        idx = 0; rdy_cnt = 0; go_wait = 0; ov_cnt = 0; dcyc = 0;
        clear_stats();
        drv_on = 1;
        n_ifmap = AW'(ni); n_wght = AW'(nw); n_bias = 2'(nb); n_ofmap = AW'(no);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_ifmap = 10'd7; n_wght = 10'd7; n_bias = 2'd3; n_ofmap = 10'd7;
    endtask

    task automatic run_tile(input logic [15:0] t, input int ni, input int nw, input int nb,
                            input int no, input int vp, input int ack, input int stl);
        int nbe;
        nbe = BIAS_ON ? nb : 0;
        launch(t, ni, nw, nb, no, vp, ack, stl);
        for (int k = 0; k < 2000 && done_cnt == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("op_done_count", done_cnt, 1);
        chk("idle_after_tile", busy, 0);
        chk("cfg_load_count", cl_cnt, 1);
        chk("cfg_done_count", cd_cnt, 1);
        chk("start_to_cfg_load", cl_cyc - start_cyc, 1);
        chk("cfg_load_to_done", cd_cyc - cl_cyc, 1);
        chk("cfg_load_to_in_ready", ir_first - cl_cyc, 2);
        chk("ifmap_write_count", if_q.size(), ni);
        for (int i = 0; i < if_q.size(); i++) begin
            chk($sformatf("ifmap_addr[%0d]", i), if_q[i].addr, i);
            chk($sformatf("ifmap_data[%0d]", i), if_q[i].data, word(t, i));
            chk($sformatf("ifmap_wen[%0d]", i), if_q[i].wen, 8'hFF);
        end
        chk("wght_write_count", wt_q.size(), nw + nbe);
        for (int i = 0; i < wt_q.size(); i++) begin
            chk($sformatf("wght_addr[%0d]", i), wt_q[i].addr, (i < nw) ? i : i - nw);
            chk($sformatf("wght_data[%0d]", i), wt_q[i].data, word(t, ni + i));
            chk($sformatf("wght_wen[%0d]", i), wt_q[i].wen, 8'hFF);
            chk($sformatf("bias_write[%0d]", i), wt_q[i].bw, (i >= nw) ? 1 : 0);
        end
        if (vp == 0) begin
            chk("in_ready_cycles", ir_cycles, ni + nw + nbe);
            chk("bias_write_cycles", bw_cycles, nbe);
        end
        if (wt_q.size() > 0) chk("wait_rdy_after_last_wght", rdy_first - wt_last, 1);
        chk("ready_hold_cycles", rdy_cycles, ack + 1);
        chk("ready_pair_equal", rw_diff, 0);
        chk("op_go_count", go_cnt, 1);
        chk("ack_to_op_go", go_cyc - rdy_last, 1);
        chk("ofmap_en_count", of_cnt, no);
        if (no > 0) chk("tile_done_to_ofmap_en", of_first - td_cyc, 1);
        chk("out_word_count", out_q.size(), no);
        for (int i = 0; i < out_q.size(); i++)
            chk($sformatf("out_data[%0d]", i), out_q[i], ofm(AW'(i)));
        chk("out_valid_cycles", ov_cycles, no * (stl + 1));
        chk("out_data_stable", unstable, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        n_ifmap = '0; n_wght = '0; n_bias = '0; n_ofmap = '0;
        tile_id = '0; vpat = 0; ack_dly = 0; stall = 0;
        idx = 0; rdy_cnt = 0; go_wait = 0; ov_cnt = 0; dcyc = 0;
        clear_stats();
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs_zero",
            {63'b0, |{in_ready, out_valid, out_data, config_load, config_done, ifmap_en, ifmap_wen,
                      ifmap_addrin, ifmap_din, wght_en, wght_wen, wght_addrin, wght_din, bias_write,
                      ifmap_ready, wght_ready, op_go, op_done, ofmap_en, ofmap_addrin, busy}}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full tile, continuous stream
        run_tile(16'h0001, 4, 3, 2, 2, 0, 0, 0);
        // Zero counts: ifmap and bias skipped
        run_tile(16'h0002, 0, 3, 0, 1, 0, 0, 0);
        // Backpressure on both streams
        run_tile(16'h0003, 4, 3, 1, 2, 1, 0, 5);
        // Late acknowledge, no readback
        run_tile(16'h0004, 2, 2, 2, 0, 0, 10, 0);

        // Reset mid-load after 2 of 4 ifmap words
        launch(16'h0005, 4, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 100 && if_q.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_ifmap_en", ifmap_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("reset_ifmap_en_drop", ifmap_en, 0);
        chk("reset_mid_busy", busy, 0);
        chk("reset_mid_outputs_zero",
            {63'b0, |{in_ready, out_valid, out_data, config_load, config_done, ifmap_en, ifmap_wen,
                      ifmap_addrin, ifmap_din, wght_en, wght_wen, wght_addrin, wght_din, bias_write,
                      ifmap_ready, wght_ready, op_go, op_done, ofmap_en, ofmap_addrin, busy}}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_write_count", if_q.size(), 2);
        chk("reset_stays_idle", busy, 0);
        run_tile(16'h0006, 4, 3, 2, 2, 0, 0, 0);

        drv_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
